// File: rtl/dc_pkg.sv
// rtl/dc_pkg.sv - shared sample type and sizing helpers for the delay-commutator stage
package dc_pkg;

  localparam int DC_DATA_WIDTH = 32;

  typedef logic [DC_DATA_WIDTH-1:0] sample_t;

  // Width of the beat counter that runs modulo 2*delay.
  function automatic int cnt_width(input int delay);
    return (delay < 1) ? 1 : $clog2(2 * delay);
  endfunction

  // Width of the saturating priming counter, which must be able to hold delay itself.
  function automatic int prime_width(input int delay);
    return (delay < 1) ? 1 : $clog2(delay + 1);
  endfunction

  // Bit of the beat counter that selects the commutator position.
  function automatic int sel_bit(input int delay);
    return (delay < 2) ? 0 : $clog2(delay);
  endfunction

endpackage

// File: rtl/dc_delay_line.sv
// rtl/dc_delay_line.sv - enable-gated multi-channel shift register with synchronous clear
module dc_delay_line
  import dc_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = DC_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              en,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] din,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0] dout
);

  logic [DEPTH-1:0][NUM_CH-1:0][DATA_WIDTH-1:0] taps;

  // Shift one word per channel in on every enabled cycle; the oldest tap is DEPTH beats old.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      taps <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/dc_stage_mc.sv
// rtl/dc_stage_mc.sv - multi-channel delay-commutator stage; optional DC_BYPASS_EN adds a bypass input
module dc_stage_mc
  import dc_pkg::*;
#(
  parameter int DATA_WIDTH = DC_DATA_WIDTH,
  parameter int DELAY      = 4,
  parameter int NUM_CH     = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  input  logic                              sync,
`ifdef DC_BYPASS_EN
  input  logic                              bypass,
`endif
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] x0,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] x1,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0] y0,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0] y1,
  output logic                              out_valid
);

  localparam int CW = cnt_width(DELAY);
  localparam int PW = prime_width(DELAY);
  localparam int SB = sel_bit(DELAY);
  localparam logic [PW-1:0] PRIME_FULL = PW'(DELAY);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;
  logic [PW-1:0] prime;
  logic          sel;
  logic          bypass_on;
  logic          shift_en;

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] b;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] u;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] l;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] u_del;

`ifdef DC_BYPASS_EN
  assign bypass_on = bypass;
`else
  assign bypass_on = 1'b0;
`endif

  // A sync beat is handled as position 0 of a new frame.
  assign cnt_eff  = sync ? '0 : cnt;
  assign sel      = cnt_eff[SB];
  assign shift_en = in_valid && !bypass_on;

  // Lower lane is delayed before the commutator.
  dc_delay_line #(
    .DEPTH      (DELAY),
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lower_line (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (shift_en),
    .din     (x1),
    .dout    (b)
  );

  // The same select drives every channel; each channel only sees its own words.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_switch
    assign u[ch] = sel ? b[ch]  : x0[ch];
    assign l[ch] = sel ? x0[ch] : b[ch];
  end

  // Upper lane is delayed after the commutator.
  dc_delay_line #(
    .DEPTH      (DELAY),
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_upper_line (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (shift_en),
    .din     (u),
    .dout    (u_del)
  );

  // Frame position and priming count advance only on accepted beats; bypass beats keep the frame position.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= '0;
      prime <= '0;
    end else if (in_valid) begin
      if (prime < PRIME_FULL) begin
        prime <= prime + PW'(1);
      end
      if (!bypass_on) begin
        cnt <= cnt_eff + CW'(1);
      end
    end
  end

  // Output pair is captured on accepted beats and flagged valid once the delay lines are primed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y0        <= '0;
      y1        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (bypass_on) begin
          y0        <= x0;
          y1        <= x1;
          out_valid <= 1'b1;
        end else begin
          y0        <= u_del;
          y1        <= l;
          out_valid <= (prime >= PRIME_FULL);
        end
      end
    end
  end

endmodule

// File: tb/tb_dc_stage_mc.sv
// tb/tb_dc_stage_mc.sv - scoreboard bench for dc_stage_mc at DELAY=2/NUM_CH=1 and DELAY=4/NUM_CH=2
module tb_dc_stage_mc;
  import dc_pkg::*;

  localparam int DA   = 2;
  localparam int DB   = 4;
  localparam int MAXN = 4096;

  typedef struct {
    sample_t y0 [2];
    sample_t y1 [2];
    int      due;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             sync;
  logic [1:0][31:0] x0;
  logic [1:0][31:0] x1;
  logic [0:0][31:0] ya0;
  logic [0:0][31:0] ya1;
  logic [1:0][31:0] yb0;
  logic [1:0][31:0] yb1;
  logic             va;
  logic             vb;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t    qa[$];
  exp_t    qb[$];
  sample_t obs0[$];
  sample_t obs1[$];

  // Reference history: every accepted beat since reset, per instance and channel.
  sample_t hx0 [2][2][MAXN];
  sample_t hx1 [2][2][MAXN];
  bit      hs  [2][MAXN];
  int      nb  [2];
  int      ph  [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dc_stage_mc #(.DATA_WIDTH(32), .DELAY(DA), .NUM_CH(1)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .sync      (sync),
    .x0        (x0[0:0]),
    .x1        (x1[0:0]),
    .y0        (ya0),
    .y1        (ya1),
    .out_valid (va)
  );

  dc_stage_mc #(.DATA_WIDTH(32), .DELAY(DB), .NUM_CH(2)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .sync      (sync),
    .x0        (x0),
    .x1        (x1),
    .y0        (yb0),
    .y1        (yb1),
    .out_valid (vb)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic sample_t hist(input int i, input int c, input int m, input bit upper);
    if (m < 0) return '0;
    return upper ? hx0[i][c][m] : hx1[i][c][m];
  endfunction

  // Beat n: s from frame position; b(n) = x1(n-d); u(n) = s ? b(n) : x0(n); y0 = u(n-d); y1 = s ? x0(n) : b(n).
  task automatic model_beat(input int i, input int d, output bit v, output exp_t e);
    int eff;
    int m;
    bit s;
    eff = sync ? 0 : ph[i];
    s   = ((eff / d) % 2) == 1;
    for (int c = 0; c < 2; c++) begin
      hx0[i][c][nb[i]] = x0[c];
      hx1[i][c][nb[i]] = x1[c];
    end
    hs[i][nb[i]] = s;
    v = nb[i] >= d;
    m = nb[i] - d;
    for (int c = 0; c < 2; c++) begin
      e.y1[c] = s ? x0[c] : hist(i, c, m, 1'b0);
      if (m < 0)
        e.y0[c] = '0;
      else
        e.y0[c] = hs[i][m] ? hist(i, c, m - d, 1'b0) : hist(i, c, m, 1'b1);
    end
    e.due = cyc + 1;
    ph[i] = (eff + 1) % (2 * d);
    if (nb[i] < MAXN - 1) nb[i]++;
  endtask

  task automatic step(input bit v, input bit sy, input sample_t a0, input sample_t b0,
                      input sample_t a1, input sample_t b1);
    bit   ok;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    sync     = sy;
    x0[0] = a0; x0[1] = b0;
    x1[0] = a1; x1[1] = b1;
    if (v) begin
      model_beat(0, DA, ok, e);
      if (ok) qa.push_back(e);
      model_beat(1, DB, ok, e);
      if (ok) qb.push_back(e);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'($urandom);
    sync     = 1'($urandom);
    x0       = {$urandom, $urandom};
    x1       = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0;
      ph[i] = 0;
    end
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    sync     = 1'b0;
    @(negedge clk);
    chk("rst_a_valid", va, 0);
    chk("rst_a_y0", ya0, 0);
    chk("rst_a_y1", ya1, 0);
    chk("rst_b_valid", vb, 0);
    chk("rst_b_y0", yb0, 0);
    chk("rst_b_y1", yb1, 0);
  endtask

  task automatic directed(input bit gaps);
    sample_t e0 [4];
    sample_t e1 [4];
    e0 = '{32'd0, 32'd1, 32'd4, 32'd5};
    e1 = '{32'd2, 32'd3, 32'd6, 32'd7};
    apply_reset();
    obs0.delete();
    obs1.delete();
    step(1, 0, 0, 100, 4, 104);
    step(1, 0, 1, 101, 5, 105);
    if (gaps) repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 2, 102, 6, 106);
    step(1, 0, 3, 103, 7, 107);
    repeat (12) step(1, 0, 0, 100, 0, 100);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    chk(gaps ? "gap_pair_count" : "dir_pair_count", obs0.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      if (k < obs0.size()) begin
        chk(gaps ? "gap_y0" : "dir_y0", obs0[k], e0[k]);
        chk(gaps ? "gap_y1" : "dir_y1", obs1[k], e1[k]);
      end
    end
  endtask

  // Monitor: each scheduled pair must appear exactly on its cycle; out_valid must be low otherwise.
  always @(negedge clk) begin
    if (qa.size() > 0 && qa[0].due == cyc) begin
      chk("a_valid", va, 1);
      if (va) begin
        chk("a_y0", ya0[0], qa[0].y0[0]);
        chk("a_y1", ya1[0], qa[0].y1[0]);
      end
      void'(qa.pop_front());
    end else begin
      chk("a_idle", va, 0);
    end
    if (va) begin
      obs0.push_back(ya0[0]);
      obs1.push_back(ya1[0]);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      chk("b_valid", vb, 1);
      if (vb) begin
        for (int c = 0; c < 2; c++) begin
          chk("b_y0", yb0[c], qb[0].y0[c]);
          chk("b_y1", yb1[c], qb[0].y1[c]);
        end
      end
      void'(qb.pop_front());
    end else begin
      chk("b_idle", vb, 0);
    end
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    x0       = '0;
    x1       = '0;
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0;
      ph[i] = 0;
    end

    directed(1'b0);
    directed(1'b1);

    apply_reset();
    for (int k = 0; k < 12; k++) begin
      step(1, k == 5, $urandom, $urandom, $urandom, $urandom);
    end

    for (int r = 0; r < 4; r++) begin
      apply_reset();
      repeat (200) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
             $urandom, $urandom, $urandom, $urandom);
      end
    end
    apply_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0);

    chk("a_drained", qa.size(), 0);
    chk("b_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dc_stage_mc.md
DC_STAGE_MC -- requirements
Module: dc_stage_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, width of one sample word.
REQ-002 SHALL have parameter DELAY, 4, commutator delay in accepted beats; power of two, at least 1.
REQ-003 SHALL have parameter NUM_CH, 2, number of parallel MIMO channels sharing one control path.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  accept beat; all state advances only when high.
REQ-007 SHALL have port sync  input  1  frame alignment; qualified by in_valid.
REQ-008 SHALL have port x0  input  NUM_CH x DATA_WIDTH  upper lane, one word per channel.
REQ-009 SHALL have port x1  input  NUM_CH x DATA_WIDTH  lower lane, one word per channel.
REQ-010 SHALL have port y0  output  NUM_CH x DATA_WIDTH  registered upper output.
REQ-011 SHALL have port y1  output  NUM_CH x DATA_WIDTH  registered lower output.
REQ-012 SHALL have port out_valid  output  1  registered; y0/y1 hold a valid pair.

Function
REQ-013 SHALL keep a beat counter cnt, modulo 2*DELAY, incremented on each accepted beat; switch select s = cnt bit log2(DELAY).
REQ-014 SHALL form b = x1 delayed DELAY accepted beats; s=0: u=x0, l=b; s=1: u=b, l=x0.
REQ-015 SHALL register y0 = u delayed DELAY accepted beats and y1 = l on the clock edge of each accepted beat.
REQ-016 SHALL hold cnt, delay lines, y0, y1 unchanged on any cycle with in_valid low; out_valid SHALL be low on the following cycle.
REQ-017 SHALL count accepted beats since reset in a saturating prime counter; out_valid SHALL be registered as in_valid AND (prime count >= DELAY).
REQ-018 SHALL treat an accepted beat with sync high as cnt=0 for that beat (next cnt=1); prime counter and delay contents unaffected; sync ignored when in_valid low.
REQ-019 SHALL apply one cnt/select to all NUM_CH channels; channels SHALL never mix data.
REQ-020 SHALL wrap cnt from 2*DELAY-1 to 0 without gap; back-to-back frames stream continuously.

Reset
REQ-021 SHALL on clk edge with reset_n low clear cnt, prime counter, all delay-line words, y0, y1, out_valid to 0, overriding in_valid and sync.
REQ-022 SHALL after reset mid-operation re-prime: out_valid low until DELAY accepted beats seen again.

Configuration
REQ-023 SHALL, with DC_BYPASS_EN defined, add input port bypass (1 bit); on accepted beat with bypass high, y0=x0, y1=x1 registered, out_valid high next cycle, cnt and delay lines held.
REQ-024 SHALL, without DC_BYPASS_EN, have no bypass port and behave per REQ-013..REQ-020 only.

Structure
REQ-025 SHALL take sample type, default DATA_WIDTH, and counter-width function from shared package dc_pkg.
REQ-026 SHALL instantiate sub-module dc_delay_line (DELAY-deep, NUM_CH-wide, enable-gated shift register with sync clear) twice: lower pre-switch, upper post-switch.

Verification
REQ-027 DELAY=2, NUM_CH=1, in_valid high: beats (x0,x1)=(0,4),(1,5),(2,6),(3,7) then zeros -> out_valid pairs (0,2),(1,3),(4,6),(5,7), first on cycle after beat 2.
REQ-028 DELAY=4, NUM_CH=2, channel1 = channel0+100, 16-beat frame -> each channel matches single-channel model, channel1 offset by 100 exactly.
REQ-029 Same stimulus as REQ-027, in_valid low for 3 cycles between beats 1 and 2 -> identical pair sequence, out_valid low during and one cycle after gaps.
REQ-030 Sync pulse on beat 5 of a DELAY=2 stream -> switch select for beats 5..8 = 0,0,1,1.
REQ-031 reset_n low one cycle after beat 3 -> all outputs 0 next cycle; out_valid low for next DELAY accepted beats.
REQ-032 DC_BYPASS_EN defined, bypass high, x0=9, x1=17 -> y0=9, y1=17, out_valid high one cycle later; cnt unchanged.
